// File: rtl/osc_mon_pkg.sv
// Shared definitions for the oscillator frequency monitor: FSM state
// encoding and default configuration constants.
package osc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        GATE,
        UPDATE
    } mon_state_t;

    localparam int unsigned DEF_GATE_CYCLES = 50000;  // 1 ms at 50 MHz
    localparam int unsigned DEF_LOSS_CYCLES = 1024;
    localparam int unsigned DEF_CNT_W       = 20;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/osc_mon_edge_sync.sv
// Brings the asynchronous MON_CLK into the CLK domain through a flop chain
// and emits a one-cycle pulse per MON_CLK rising edge.
module osc_mon_edge_sync
    import osc_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic MON_CLK,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    // primed_q[k] is set once stage k of sync_q/prev_q holds a real sample,
    // so reset values are never mistaken for a low-to-high transition.
    logic [SYNC_STAGES:0]   primed_q;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("osc_mon_edge_sync: SYNC_STAGES must be at least 2");
    end

    // Synchronizer chain, previous-sample flop and priming shift register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            primed_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop load its pre-edge
            // neighbour value, which is what makes this a shift chain.
            sync_q   <= {sync_q[SYNC_STAGES-2:0], MON_CLK};
            prev_q   <= sync_q[SYNC_STAGES-1];
            primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A level that is already high when sampling starts is not an edge.
    assign edge_pulse = primed_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/osc_freq_monitor.sv
// Oscillator frequency monitor: counts MON_CLK rising edges over a fixed
// gate window of CLK cycles and compares the count against a bound pair.
// Optional feature macro OSC_FREQ_MONITOR_LOSS_DETECT_EN adds a watchdog
// that raises LOSS (and FAULT) when MON_CLK stops toggling.
module osc_freq_monitor
    import osc_mon_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned LOSS_CYCLES = DEF_LOSS_CYCLES
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             MON_CLK,
    input  logic             ENABLE,
    input  logic [CNT_W-1:0] MIN_COUNT,
    input  logic [CNT_W-1:0] MAX_COUNT,
    input  logic             FAULT_CLR,
    output logic [CNT_W-1:0] COUNT,
    output logic             COUNT_VALID,
    output logic             FREQ_LOW,
    output logic             FREQ_HIGH,
    output logic             FAULT
`ifdef OSC_FREQ_MONITOR_LOSS_DETECT_EN
    ,
    output logic             LOSS
`endif
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("osc_freq_monitor: GATE_CYCLES must be at least 2");
    end
    if (LOSS_CYCLES < 2) begin : g_bad_loss
        $error("osc_freq_monitor: LOSS_CYCLES must be at least 2");
    end

    mon_state_t        state;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              edge_pulse;
    logic              window_fault;
    logic              loss_set;

    osc_mon_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .MON_CLK   (MON_CLK),
        .edge_pulse(edge_pulse)
    );

    // Measurement FSM with its gate/edge counters and registered results.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            COUNT       <= '0;
            COUNT_VALID <= 1'b0;
            FREQ_LOW    <= 1'b0;
            FREQ_HIGH   <= 1'b0;
        end else begin
            COUNT_VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ENABLE) state <= ARM;
                end
                ARM: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    state    <= ENABLE ? GATE : IDLE;
                end
                GATE: begin
                    if (!ENABLE) begin
                        state <= IDLE;
                    end else begin
                        // Saturate rather than wrap so a runaway oscillator
                        // still reads as too fast.
                        if (edge_pulse && (edge_cnt != '1))
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        gate_cnt <= gate_cnt + GATE_W'(1);
                        if (gate_cnt == GATE_LAST) state <= UPDATE;
                    end
                end
                UPDATE: begin
                    COUNT       <= edge_cnt;
                    FREQ_LOW    <= (edge_cnt < MIN_COUNT);
                    FREQ_HIGH   <= (edge_cnt > MAX_COUNT);
                    COUNT_VALID <= 1'b1;
                    state       <= ENABLE ? ARM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign window_fault = COUNT_VALID & (FREQ_LOW | FREQ_HIGH);

    // Sticky fault flag; a new fault outranks a simultaneous clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            FAULT <= 1'b0;
        else if (window_fault || loss_set)
            FAULT <= 1'b1;
        else if (FAULT_CLR)
            FAULT <= 1'b0;
    end

`ifdef OSC_FREQ_MONITOR_LOSS_DETECT_EN
    localparam int unsigned WD_W = $clog2(LOSS_CYCLES + 1);

    // Number of cycles elapsed since the last edge pulse, parked at LOSS_CYCLES.
    logic [WD_W-1:0] wd_cnt;

    assign loss_set = ENABLE && !edge_pulse && (wd_cnt == WD_W'(LOSS_CYCLES - 1));

    // Loss-of-clock watchdog, running only while measurement is enabled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wd_cnt <= '0;
            LOSS   <= 1'b0;
        end else if (!ENABLE) begin
            wd_cnt <= '0;
            LOSS   <= 1'b0;
        end else if (edge_pulse) begin
            wd_cnt <= WD_W'(1);
            LOSS   <= 1'b0;
        end else if (loss_set) begin
            wd_cnt <= WD_W'(LOSS_CYCLES);
            LOSS   <= 1'b1;
        end else if (wd_cnt != WD_W'(LOSS_CYCLES)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign loss_set = 1'b0;
`endif

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Directed bench for osc_freq_monitor with a shortened gate window.
// CLK period 20, MON_CLK half-periods: 500 (nominal, 20 edges per window),
// 625 (slow, 16 edges), 30 (fast, saturates an 8-bit count).
module tb_osc_freq_monitor;

    localparam int unsigned GATE   = 1000;
    localparam int unsigned CW     = 8;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned LOSS_N = 200;

    logic          clk;
    logic          rst_n;
    logic          mon_clk;
    logic          enable;
    logic          fault_clr;
    logic [CW-1:0] min_count;
    logic [CW-1:0] max_count;
    logic [CW-1:0] count;
    logic          count_valid;
    logic          freq_low;
    logic          freq_high;
    logic          fault;
`ifdef OSC_FREQ_MONITOR_LOSS_DETECT_EN
    logic          loss;
`endif

    int errors = 0;
    int checks = 0;
    int mon_half = 500;
    bit mon_run = 1'b1;

    osc_freq_monitor #(
        .GATE_CYCLES(GATE),
        .CNT_W      (CW),
        .SYNC_STAGES(SYNC),
        .LOSS_CYCLES(LOSS_N)
    ) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .MON_CLK    (mon_clk),
        .ENABLE     (enable),
        .MIN_COUNT  (min_count),
        .MAX_COUNT  (max_count),
        .FAULT_CLR  (fault_clr),
        .COUNT      (count),
        .COUNT_VALID(count_valid),
        .FREQ_LOW   (freq_low),
        .FREQ_HIGH  (freq_high),
        .FAULT      (fault)
`ifdef OSC_FREQ_MONITOR_LOSS_DETECT_EN
        ,
        .LOSS       (loss)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Toggle times stay off the CLK edges (offset 3, half-periods multiple of 5).
    initial begin
        mon_clk = 1'b0;
        #3;
        forever begin
            #(mon_half);
            if (mon_run) mon_clk = ~mon_clk;
        end
    end

    // Waits at negedges for COUNT_VALID; n = negedges consumed.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!count_valid && n < budget);
        if (!count_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: no COUNT_VALID within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; fault_clr = 1'b0;
        min_count = 8'd19; max_count = 8'd21;
        repeat (3) @(negedge clk);
        checks++;
        if (count !== 8'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if ({count_valid, freq_low, freq_high, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got valid/low/high/fault=%b expected 0000",
                     {count_valid, freq_low, freq_high, fault});
        end
`ifdef OSC_FREQ_MONITOR_LOSS_DETECT_EN
        checks++;
        if (loss !== 1'b0) begin
            errors++; $display("FAIL reset_loss: got %b expected 0", loss);
        end
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nominal();
        int n;
        enable = 1'b1;
        wait_valid(GATE + 10, n);
        checks++;
        if (n !== GATE + 3) begin
            errors++; $display("FAIL nominal_latency: got %0d cycles expected %0d", n, GATE + 3);
        end
        checks++;
        if (count !== 8'd20) begin
            errors++; $display("FAIL nominal_count: got %0d expected 20", count);
        end
        checks++;
        if ({freq_low, freq_high} !== 2'b00) begin
            errors++; $display("FAIL nominal_flags: got low/high=%b expected 00", {freq_low, freq_high});
        end
        @(negedge clk);
        checks++;
        if (count_valid !== 1'b0) begin
            errors++; $display("FAIL valid_width: got %b expected 0", count_valid);
        end
        wait_valid(GATE + 10, n);
        checks++;
        if (n + 1 !== GATE + 2) begin
            errors++; $display("FAIL nominal_period: got %0d cycles expected %0d", n + 1, GATE + 2);
        end
        checks++;
        if (count !== 8'd20) begin
            errors++; $display("FAIL nominal_count2: got %0d expected 20", count);
        end
    endtask

    task automatic test_bounds();
        int n;
        min_count = 8'd20; max_count = 8'd20;
        wait_valid(GATE + 10, n);
        checks++;
        if ({freq_low, freq_high} !== 2'b00) begin
            errors++; $display("FAIL bounds_inclusive: got low/high=%b expected 00", {freq_low, freq_high});
        end
        min_count = 8'd21; max_count = 8'd19;
        wait_valid(GATE + 10, n);
        checks++;
        if ({freq_low, freq_high} !== 2'b11) begin
            errors++; $display("FAIL bounds_inverted: got low/high=%b expected 11", {freq_low, freq_high});
        end
        min_count = 8'd19; max_count = 8'd21;
        @(negedge clk);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL bounds_fault: got %b expected 1", fault);
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL fault_clear: got %b expected 0", fault);
        end
    endtask

    task automatic test_low_freq();
        int n;
        mon_half = 625;
        wait_valid(GATE + 10, n);
        wait_valid(GATE + 10, n);
        checks++;
        if (count !== 8'd16) begin
            errors++; $display("FAIL low_count: got %0d expected 16", count);
        end
        checks++;
        if ({freq_low, freq_high} !== 2'b10) begin
            errors++; $display("FAIL low_flags: got low/high=%b expected 10", {freq_low, freq_high});
        end
        @(negedge clk);
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL low_fault: got %b expected 1", fault);
        end
        mon_half = 500;
        wait_valid(GATE + 10, n);
        wait_valid(GATE + 10, n);
        checks++;
        if ({count, freq_low} !== {8'd20, 1'b0}) begin
            errors++; $display("FAIL recover_count: got count=%0d low=%b expected 20/0", count, freq_low);
        end
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL fault_sticky: got %b expected 1", fault);
        end
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL recover_clear: got %b expected 0", fault);
        end
    endtask

    task automatic test_saturation();
        int n;
        min_count = 8'd0; max_count = 8'd200;
        mon_half = 30;
        wait_valid(GATE + 10, n);
        wait_valid(GATE + 10, n);
        checks++;
        if (count !== 8'd255) begin
            errors++; $display("FAIL sat_count: got %0d expected 255", count);
        end
        checks++;
        if ({freq_low, freq_high} !== 2'b01) begin
            errors++; $display("FAIL sat_flags: got low/high=%b expected 01", {freq_low, freq_high});
        end
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            errors++; $display("FAIL sat_clear: got %b expected 0", fault);
        end
        wait_valid(GATE + 10, n);
        checks++;
        if ({freq_high, fault} !== 2'b10) begin
            errors++; $display("FAIL sat_pre_coincide: got high/fault=%b expected 10", {freq_high, fault});
        end
        fault_clr = 1'b1;  // lands in the fault-setting COUNT_VALID cycle
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL set_wins: got %b expected 1", fault);
        end
    endtask

    task automatic test_abort();
        int n;
        bit seen;
        mon_half = 500;
        min_count = 8'd19; max_count = 8'd21;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 402; i++) begin
            @(negedge clk);
            if (count_valid) seen = 1'b1;
        end
        enable = 1'b0;
        for (int i = 0; i < GATE + 10; i++) begin
            @(negedge clk);
            if (count_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_valid: got a COUNT_VALID pulse expected none");
        end
        checks++;
        if ({count, freq_high} !== {8'd255, 1'b1}) begin
            errors++; $display("FAIL abort_hold: got count=%0d high=%b expected 255/1", count, freq_high);
        end
        enable = 1'b1;
        wait_valid(GATE + 10, n);
        checks++;
        if (n !== GATE + 3) begin
            errors++; $display("FAIL reenable_latency: got %0d cycles expected %0d", n, GATE + 3);
        end
        checks++;
        if (count !== 8'd20) begin
            errors++; $display("FAIL reenable_count: got %0d expected 20", count);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (300) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({count, count_valid, freq_low, freq_high, fault} !== '0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d valid/low/high/fault=%b expected all 0",
                     count, {count_valid, freq_low, freq_high, fault});
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(GATE + 10, n);
        checks++;
        if (n !== GATE + 3) begin
            errors++; $display("FAIL restart_latency: got %0d cycles expected %0d", n, GATE + 3);
        end
        checks++;
        if ($isunknown(count) || count < 8'd19 || count > 8'd21) begin
            errors++; $display("FAIL restart_count: got %0d expected 19..21", count);
        end
        // Park MON_CLK high across a reset: that level must not count as an edge.
        n = 0;
        while (mon_clk !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        mon_run = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(GATE + 10, n);
        checks++;
        if ({count, freq_low} !== {8'd0, 1'b1}) begin
            errors++; $display("FAIL high_at_release: got count=%0d low=%b expected 0/1", count, freq_low);
        end
        mon_run = 1'b1;
        repeat (100) @(negedge clk);
    endtask

`ifdef OSC_FREQ_MONITOR_LOSS_DETECT_EN
    task automatic test_loss();
        int n;
        min_count = 8'd0; max_count = 8'd255;
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n = 0;
        while (mon_clk !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (mon_clk !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        mon_run = 1'b0;
        n = 0;
        while (loss !== 1'b1 && n < LOSS_N + 20) begin @(negedge clk); n++; end
        checks++;
        if (n < LOSS_N + SYNC - 1 || n > LOSS_N + SYNC) begin
            errors++; $display("FAIL loss_time: got %0d cycles expected %0d..%0d",
                               n, LOSS_N + SYNC - 1, LOSS_N + SYNC);
        end
        checks++;
        if (fault !== 1'b1) begin
            errors++; $display("FAIL loss_fault: got %b expected 1", fault);
        end
        mon_run = 1'b1;
        n = 0;
        while (loss !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (loss !== 1'b0) begin
            errors++; $display("FAIL loss_clear: got %b expected 0", loss);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_bounds();
        test_low_freq();
        test_saturation();
        test_abort();
        test_reset_mid();
`ifdef OSC_FREQ_MONITOR_LOSS_DETECT_EN
        test_loss();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osc_freq_monitor.md
OSC_FREQ_MONITOR -- requirements
Module: osc_freq_monitor

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000, meaning the gate window length in CLK cycles (1 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, meaning the width of the edge count and the bounds.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the number of MON_CLK synchronizer flops (minimum 2).
REQ-004 SHALL have parameter LOSS_CYCLES, default 1024, meaning the CLK cycles without a MON_CLK edge before LOSS asserts.
REQ-005 SHALL have port CLK, input, 1 bit: the single fabric clock, which is the only clock in the block.
REQ-006 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port MON_CLK, input, 1 bit: the oscillator output being monitored; asynchronous to CLK, frequency below CLK/2.
REQ-008 SHALL have port ENABLE, input, 1 bit: level-sensitive run enable for measurement.
REQ-009 SHALL have ports MIN_COUNT and MAX_COUNT, input, CNT_W bits each: the inclusive acceptable edge-count range.
REQ-010 SHALL have port FAULT_CLR, input, 1 bit: single-cycle pulse that clears FAULT.
REQ-011 SHALL have port COUNT, output, CNT_W bits: MON_CLK rising edges counted in the last completed window.
REQ-012 SHALL have port COUNT_VALID, output, 1 bit: one-cycle pulse when COUNT and the flags update.
REQ-013 SHALL have ports FREQ_LOW and FREQ_HIGH, output, 1 bit each: result of comparing COUNT against the bounds.
REQ-014 SHALL have port FAULT, output, 1 bit: sticky fault flag.
REQ-015 SHALL have port LOSS, output, 1 bit: present only when the loss-detect feature is compiled in (REQ-034).

Function
REQ-016 SHALL pass MON_CLK through SYNC_STAGES flops, then rising-edge detect it, producing one edge pulse per MON_CLK period.
REQ-017 SHALL implement FSM states IDLE, ARM, GATE and UPDATE.
REQ-018 SHALL stay in IDLE while ENABLE=0, and move IDLE->ARM on ENABLE=1.
REQ-019 SHALL hold ARM for exactly 1 cycle, clearing the edge counter and the gate counter, then move to GATE.
REQ-020 SHALL hold GATE for exactly GATE_CYCLES cycles, incrementing the edge counter on each edge pulse, then move to UPDATE.
REQ-021 SHALL not count an edge pulse that coincides with an ARM or UPDATE cycle.
REQ-022 SHALL saturate the edge counter at 2^CNT_W-1 and never wrap.
REQ-023 SHALL, in UPDATE (1 cycle), register COUNT, FREQ_LOW and FREQ_HIGH and pulse COUNT_VALID in the next cycle; the next state is ARM if ENABLE=1, else IDLE.
REQ-024 SHALL set FREQ_LOW = (count < MIN_COUNT) and FREQ_HIGH = (count > MAX_COUNT), as unsigned compares on bounds sampled in UPDATE; if MIN_COUNT > MAX_COUNT both flags may assert together.
REQ-025 SHALL produce the first COUNT_VALID exactly GATE_CYCLES+3 cycles after the first ENABLE=1 cycle, with subsequent pulses every GATE_CYCLES+2 cycles.
REQ-026 SHALL, when ENABLE falls during ARM or GATE, abort to IDLE on the next cycle with no COUNT_VALID, leaving COUNT and the flags unchanged.
REQ-027 SHALL set FAULT in the COUNT_VALID cycle if FREQ_LOW or FREQ_HIGH is set; FAULT clears only on FAULT_CLR, and a set in the same cycle as FAULT_CLR wins.

Reset
REQ-028 SHALL, on RESET_N low, asynchronously force FSM=IDLE, all counters and synchronizer flops to 0, COUNT=0, COUNT_VALID=0, FREQ_LOW=0, FREQ_HIGH=0, FAULT=0 and LOSS=0.
REQ-029 SHALL restart from IDLE after reset mid-window, discarding the partial count.
REQ-030 SHALL treat the edge detector's first cycle after reset release as "previous=0", so a MON_CLK that is high at release counts as no edge until it toggles.

Configuration
REQ-031 SHALL use macro OSC_FREQ_MONITOR_LOSS_DETECT_EN.
REQ-032 SHALL, when the macro is defined, run a watchdog counter while ENABLE=1 that resets on every edge pulse; reaching LOSS_CYCLES sets LOSS=1 and FAULT=1 immediately, without waiting for a window.
REQ-033 SHALL clear LOSS on the next edge pulse or when ENABLE=0.
REQ-034 SHALL, when the macro is undefined, contain no LOSS port and no watchdog logic; all other behaviour is identical.

Structure
REQ-035 SHALL place the FSM state enum (IDLE/ARM/GATE/UPDATE) and the default GATE_CYCLES and LOSS_CYCLES constants in shared package osc_mon_pkg.
REQ-036 SHALL put the synchronizer plus edge detector in sub-module osc_mon_edge_sync; the FSM, counters and compare stay in osc_freq_monitor.

Verification
REQ-037 SHALL verify: CLK 50 MHz, MON_CLK 1 MHz, GATE_CYCLES=50000, bounds 990/1010 -> COUNT=1000±1, no flags, COUNT_VALID every 50002 cycles.
REQ-038 SHALL verify: MON_CLK 0.9 MHz -> COUNT≈900, FREQ_LOW=1, FAULT=1; FAULT stays set after MON_CLK returns to 1 MHz until a FAULT_CLR pulse.
REQ-039 SHALL verify: CNT_W=8, MON_CLK 1 MHz -> COUNT=255 (saturated), FREQ_HIGH=1 when MAX_COUNT=200.
REQ-040 SHALL verify: ENABLE dropped at gate cycle 20000 -> no COUNT_VALID, COUNT keeps its prior value; re-enable -> first pulse GATE_CYCLES+3 cycles later.
REQ-041 SHALL verify: macro defined, MON_CLK stopped -> LOSS=1 and FAULT=1 exactly LOSS_CYCLES cycles after the last edge pulse; MON_CLK restart -> LOSS=0.
REQ-042 SHALL verify: RESET_N asserted mid-GATE -> all outputs 0 asynchronously; FAULT_CLR coincident with a fault-setting COUNT_VALID -> FAULT=1.
